// File: rtl/result_history_buffer_if.sv
// ---------------------------------------------------------------------------
// result_history_buffer_if
//
// Purpose: groups the capture/control inputs and the display outputs of the
// result history buffer into one bundle.
//
// Signals:
//   capture_valid  - one-cycle strobe, accumulator loaded a new value
//   capture_data   - accumulator value to store (DATA_W bits)
//   clear          - synchronous clear of the history, active-high
//   step_n         - raw push-button, active-low, asynchronous to the clock
//   view_data      - registered, currently selected history entry
//   view_index     - age of the selected entry (0 = newest)
//   count          - number of valid entries, 0..DEPTH
//   empty / full   - count == 0 / count == DEPTH
//   overflow       - sticky, an entry was overwritten since reset/clear
//
// Modports: master drives the inputs and observes the outputs; slave is the
// buffer itself.
// ---------------------------------------------------------------------------
interface result_history_buffer_if #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 3
);
    logic              capture_valid;
    logic [DATA_W-1:0] capture_data;
    logic              clear;
    logic              step_n;
    logic [DATA_W-1:0] view_data;
    logic [PTR_W-1:0]  view_index;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              overflow;

    modport master (
        output capture_valid, capture_data, clear, step_n,
        input  view_data, view_index, count, empty, full, overflow
    );

    modport slave (
        input  capture_valid, capture_data, clear, step_n,
        output view_data, view_index, count, empty, full, overflow
    );
endinterface

// File: rtl/result_history_buffer.sv
// ---------------------------------------------------------------------------
// result_history_buffer
//
// Purpose: keeps a circular history of the last DEPTH accumulator values.
// A push-button steps backwards through the history (wrapping back to the
// newest entry); every new capture snaps the view back to the newest value.
// When the buffer is full the oldest entry is overwritten and a sticky
// overflow flag is raised.
//
// Ports:
//   CLK    - system clock, all state updates on the rising edge
//   reset  - asynchronous active-low reset
//   bus    - result_history_buffer_if slave modport (capture inputs, clear,
//            step button, view/count/status outputs)
// ---------------------------------------------------------------------------
module result_history_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic                   CLK,
    input  logic                   reset,
    result_history_buffer_if.slave bus
);

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Storage is deliberately not reset; count == 0 masks its contents.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W:0]    count_q,      count_d;
    logic [PTR_W-1:0]  view_index_q, view_index_d;
    logic [DATA_W-1:0] view_data_q,  view_data_d;
    logic              overflow_q,   overflow_d;

    // Three-flop button synchroniser; all flops idle high (released).
    logic step_s1_q, step_s2_q, step_s3_q;
    logic step_pulse;

    logic             do_write;
    logic [PTR_W-1:0] rd_addr;

    // Falling edge of the synchronised button: one pulse per press.
    assign step_pulse = step_s3_q & ~step_s2_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        view_index_d = view_index_q;
        overflow_d   = overflow_q;
        do_write     = 1'b0;

        if (bus.clear) begin
            wr_ptr_d     = '0;
            count_d      = '0;
            view_index_d = '0;
            overflow_d   = 1'b0;
        end else if (bus.capture_valid) begin
            do_write     = 1'b1;
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            view_index_d = '0;
            if (count_q == DEPTH_CNT) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (step_pulse && (count_q != '0)) begin
            // Oldest valid entry wraps the view back to the newest one.
            if ({1'b0, view_index_q} == (count_q - CNT_ONE)) begin
                view_index_d = '0;
            end else begin
                view_index_d = view_index_q + PTR_ONE;
            end
        end

        rd_addr = wr_ptr_d - PTR_ONE - view_index_d;

        // A capture is shown in the same cycle it is written, so bypass the
        // storage array rather than read the not-yet-written location.
        if (do_write) begin
            view_data_d = bus.capture_data;
        end else if (count_d == '0) begin
            view_data_d = '0;
        end else begin
            view_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[wr_ptr_q] <= bus.capture_data;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            count_q      <= '0;
            view_index_q <= '0;
            view_data_q  <= '0;
            overflow_q   <= 1'b0;
            step_s1_q    <= 1'b1;
            step_s2_q    <= 1'b1;
            step_s3_q    <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            view_index_q <= view_index_d;
            view_data_q  <= view_data_d;
            overflow_q   <= overflow_d;
            step_s1_q    <= bus.step_n;
            step_s2_q    <= step_s1_q;
            step_s3_q    <= step_s2_q;
        end
    end

    assign bus.view_data  = view_data_q;
    assign bus.view_index = view_index_q;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.empty      = (count_q == '0);
    assign bus.full       = (count_q == DEPTH_CNT);

endmodule

// File: tb/tb_result_history_buffer.sv
// ---------------------------------------------------------------------------
// tb_result_history_buffer
//
// Purpose: self-checking bench for result_history_buffer. A behavioural
// model keeps the history as a queue (oldest first) plus the age of the
// displayed entry; button presses are modelled as edge events that take
// effect two clocks after the edge that first samples the press.
// ---------------------------------------------------------------------------
module tb_result_history_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    logic clk;
    logic reset_n;

    result_history_buffer_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

    result_history_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .CLK  (clk),
        .reset(reset_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] hist[$];
    int                age;
    bit                ovf;
    bit                prev_sample;
    bit                press_dly0;
    bit                press_dly1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        age         = 0;
        ovf         = 1'b0;
        prev_sample = 1'b1;
        press_dly0  = 1'b0;
        press_dly1  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_vd;
        exp_vd = (hist.size() == 0) ? '0 : hist[hist.size() - 1 - age];
        check({tag, ".view_data"},  32'(bus.view_data),  32'(exp_vd));
        check({tag, ".view_index"}, 32'(bus.view_index), 32'(age));
        check({tag, ".count"},      32'(bus.count),      32'(hist.size()));
        check({tag, ".empty"},      32'(bus.empty),      32'(hist.size() == 0));
        check({tag, ".full"},       32'(bus.full),       32'(hist.size() == DEPTH));
        check({tag, ".overflow"},   32'(bus.overflow),   32'(ovf));
    endtask

    // One clock: drive at negedge, apply the rules at posedge, check 1 ns later.
    task automatic tick(input string tag, input bit cap, input logic [DATA_W-1:0] data,
                        input bit clr, input bit stp_n);
        bit step_now;
        @(negedge clk);
        bus.capture_valid = cap;
        bus.capture_data  = data;
        bus.clear         = clr;
        bus.step_n        = stp_n;
        @(posedge clk);
        step_now    = press_dly1;
        press_dly1  = press_dly0;
        press_dly0  = prev_sample & ~stp_n;
        prev_sample = stp_n;
        if (clr) begin
            hist.delete();
            age = 0;
            ovf = 1'b0;
        end else if (cap) begin
            if (hist.size() == DEPTH) begin
                void'(hist.pop_front());
                ovf = 1'b1;
            end
            hist.push_back(data);
            age = 0;
        end else if (step_now && hist.size() != 0) begin
            age = (age + 1) % hist.size();
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic capture(input string tag, input logic [DATA_W-1:0] data);
        tick(tag, 1'b1, data, 1'b0, 1'b1);
    endtask

    task automatic press(input string tag);
        for (int i = 0; i < 4; i++) tick(tag, 1'b0, '0, 1'b0, 1'b0);
        tick(tag, 1'b0, '0, 1'b0, 1'b1);
    endtask

    // Asserts reset between clock edges and checks the outputs react at once.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        bus.capture_valid = 1'b0;
        bus.clear         = 1'b0;
        bus.step_n        = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.capture_valid = 1'b0;
        bus.capture_data  = '0;
        bus.clear         = 1'b0;
        bus.step_n        = 1'b1;
        reset_n           = 1'b0;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-clock, then idle and presses on an empty buffer.
        async_reset("rst_mid");
        check("rst_empty_const", 32'(bus.empty), 32'd1);
        idle("idle", 5);
        press("press_empty");
        press("press_empty2");

        // Three captures, then browse backwards with wrap.
        capture("cap3", 8'h11);
        capture("cap3", 8'h22);
        capture("cap3", 8'h33);
        check("cap3_vd_const", 32'(bus.view_data), 32'h33);
        press("browse");
        press("browse");
        press("browse");

        // Ten captures overflow an 8-entry buffer.
        for (int i = 1; i <= 10; i++) capture("fill", DATA_W'(i));
        check("fill_full_const", 32'(bus.full), 32'd1);
        check("fill_vd_const",   32'(bus.view_data), 32'h0A);
        for (int i = 0; i < 7; i++) press("browse_full");
        check("browse_vi_const", 32'(bus.view_index), 32'd7);
        check("browse_vd_const", 32'(bus.view_data), 32'h03);
        press("browse_wrap");

        // Clear beats a capture in the same cycle.
        tick("clr", 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) capture("cap4", DATA_W'(8'hA0 + i));
        tick("clr_cap", 1'b1, 8'h55, 1'b1, 1'b1);
        check("clr_cap_vd_const", 32'(bus.view_data), 32'd0);
        capture("after_clr", 8'h66);
        press("after_clr_step");

        // Capture wins over a step pulse arriving in the same cycle.
        capture("cap_step", 8'h71);
        capture("cap_step", 8'h72);
        press("to_idx1");
        press("to_idx2");
        tick("cs_fall", 1'b0, '0, 1'b0, 1'b0);
        tick("cs_hold", 1'b0, '0, 1'b0, 1'b0);
        tick("cs_cap",  1'b1, 8'h77, 1'b0, 1'b0);
        check("cs_vi_const", 32'(bus.view_index), 32'd0);
        check("cs_vd_const", 32'(bus.view_data), 32'h77);
        tick("cs_rel", 1'b0, '0, 1'b0, 1'b1);
        idle("cs_idle", 3);

        // Holding the button for 20 cycles is a single step.
        for (int i = 0; i < 20; i++) tick("hold", 1'b0, '0, 1'b0, 1'b0);
        idle("hold_rel", 4);

        // Reset in the middle of a capture burst.
        capture("burst", 8'hC1);
        capture("burst", 8'hC2);
        bus.capture_valid = 1'b1;
        async_reset("burst_rst");
        check("burst_rst_cnt_const", 32'(bus.count), 32'd0);
        capture("post_rst", 8'hA5);
        check("post_rst_vd_const", 32'(bus.view_data), 32'hA5);
        for (int i = 0; i < 9; i++) capture("post_rst_wrap", DATA_W'(8'hB0 + i));
        for (int i = 0; i < 3; i++) press("post_rst_browse");

        // Randomised traffic against the model.
        begin
            bit sn;
            sn = 1'b1;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(3) == 0) sn = ~sn;
                tick("rand", ($urandom_range(2) == 0), DATA_W'($urandom),
                     ($urandom_range(59) == 0), sn);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
